z16_program_loader: RTL and testbench

- Writer side of the Z16 instruction memory: receives a framed byte stream from a host link (UART receiver or debug bridge) and writes 16-bit instruction words into instruction memory.
- Holds the Z16 core in reset until a complete image has been written and its checksum verified.
- The core's fetch path remains the only reader of the memory.

---
 rtl/z16_program_loader.sv | 129 ++++++++++++
 tb/tb_z16_program_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_program_loader.sv
// Z16 instruction-memory loader: parses a framed host byte stream, writes 16-bit words
// and holds the core in reset until the image checksum has been verified.
module z16_program_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int unsigned MAX_WORDS = 32768,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_valid,
   output logic        o_byte_ready,
   output logic        o_wr_en,
   output logic [15:0] o_wr_addr,
   output logic [15:0] o_wr_data,
   output logic        o_cpu_rst,
   output logic        o_done,
   output logic        o_error
);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI,
      S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t      state;
   logic [7:0]  len_lo;
   logic [7:0]  data_lo;
   logic [7:0]  chk;
   logic [15:0] count;
   logic [15:0] len_word;
   logic        accept;
   logic        is_sync;

   // The WRITE cycle is the only stall point, giving the 3-cycle minimum word spacing.
   assign o_byte_ready = !i_rst && (state != S_WRITE);
   assign accept       = i_byte_valid && o_byte_ready;
   assign is_sync      = (i_byte == SYNC_BYTE);
   assign len_word     = {i_byte, len_lo};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         len_lo    <= 8'd0;
         data_lo   <= 8'd0;
         chk       <= 8'd0;
         count     <= 16'd0;
         o_wr_en   <= 1'b0;
         o_wr_addr <= BASE_ADDR;
         o_wr_data <= 16'd0;
         o_cpu_rst <= 1'b1;
         o_done    <= 1'b0;
         o_error   <= 1'b0;
      end else begin
         o_wr_en <= 1'b0;
         case (state)
            // SYNC restarts a frame from idle or from either terminal state.
            S_IDLE, S_DONE, S_ERROR: begin
               if (accept && is_sync) begin
                  state     <= S_LEN_LO;
                  chk       <= 8'd0;
                  o_wr_addr <= BASE_ADDR;
                  o_cpu_rst <= 1'b1;
                  o_done    <= 1'b0;
                  o_error   <= 1'b0;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len_lo <= i_byte;
                  state  <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  count <= len_word;
                  if (32'(len_word) > MAX_WORDS) begin
                     state     <= S_ERROR;
                     o_error   <= 1'b1;
                     o_cpu_rst <= 1'b1;
                  end else if (len_word == 16'd0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA_LO;
                  end
               end
            end
            S_DATA_LO: begin
               if (accept) begin
                  data_lo <= i_byte;
                  chk     <= chk + i_byte;
                  state   <= S_DATA_HI;
               end
            end
            S_DATA_HI: begin
               if (accept) begin
                  o_wr_data <= {i_byte, data_lo};
                  chk       <= chk + i_byte;
                  o_wr_en   <= 1'b1;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               o_wr_addr <= o_wr_addr + 16'd2;
               count     <= count - 16'd1;
               state     <= (count == 16'd1) ? S_CHECK : S_DATA_LO;
            end
            S_CHECK: begin
               if (accept) begin
                  if (i_byte == chk) begin
                     state     <= S_DONE;
                     o_done    <= 1'b1;
                     o_cpu_rst <= 1'b0;
                  end else begin
                     state     <= S_ERROR;
                     o_error   <= 1'b1;
                     o_cpu_rst <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               o_cpu_rst <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z16_program_loader.sv
// Directed bench for z16_program_loader: frame loads, checksum/length errors,
// back-pressure with continuous valid, and asynchronous mid-frame reset.
module tb_z16_program_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        cpu_rst;
   logic        done;
   logic        error;

   int vec;
   int errs;
   int wr_cnt;
   int rdy_bad;
   logic [15:0] wa[$];
   logic [15:0] wd[$];
   logic [7:0]  tx[$];

   z16_program_loader #(
      .BASE_ADDR(16'h0000),
      .MAX_WORDS(4),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_byte      (byte_in),
      .i_byte_valid(byte_valid),
      .o_byte_ready(byte_ready),
      .o_wr_en     (wr_en),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_cpu_rst   (cpu_rst),
      .o_done      (done),
      .o_error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: logs every strobe and flags ready seen high during a write cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
         wr_cnt = wr_cnt + 1;
         if (byte_ready !== 1'b0) rdy_bad = rdy_bad + 1;
      end
   end

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wr_cnt  = 0;
      rdy_bad = 0;
   endtask

   // Sends tx[] with valid held high throughout; each byte waits (bounded) for ready.
   task automatic send_stream(input string name);
      int guard;
      for (int i = 0; i < tx.size(); i++) begin
         @(negedge clk);
         byte_in    = tx[i];
         byte_valid = 1'b1;
         guard      = 0;
         while (byte_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) begin
            vec++;
            errs++;
            $display("FAIL %s: ready timeout at byte %0d, ready=%b required 1", name, i, byte_ready);
         end
         @(posedge clk);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   task automatic check_writes(input string name, input int n,
                               input logic [15:0] a0, input logic [15:0] d0,
                               input logic [15:0] a1, input logic [15:0] d1);
      vec++;
      if (wr_cnt !== n) begin
         errs++;
         $display("FAIL %s write count: got %0d required %0d", name, wr_cnt, n);
      end
      if (n >= 1 && wa.size() >= 1) begin
         vec++;
         if (wa[0] !== a0 || wd[0] !== d0) begin
            errs++;
            $display("FAIL %s write0: got (%h,%h) required (%h,%h)", name, wa[0], wd[0], a0, d0);
         end
      end
      if (n >= 2 && wa.size() >= 2) begin
         vec++;
         if (wa[1] !== a1 || wd[1] !== d1) begin
            errs++;
            $display("FAIL %s write1: got (%h,%h) required (%h,%h)", name, wa[1], wd[1], a1, d1);
         end
      end
      vec++;
      if (rdy_bad !== 0) begin
         errs++;
         $display("FAIL %s ready during write: got %0d cycles required 0", name, rdy_bad);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (3) @(negedge clk);
      check_bit("reset cpu_rst", cpu_rst, 1'b1);
      check_bit("reset done", done, 1'b0);
      check_bit("reset error", error, 1'b0);
      check_bit("reset wr_en", wr_en, 1'b0);
      check_bit("reset ready", byte_ready, 1'b0);
      vec++;
      if (wr_addr !== 16'h0000 || wr_data !== 16'h0000) begin
         errs++;
         $display("FAIL reset addr/data: got (%h,%h) required (0000,0000)", wr_addr, wr_data);
      end
      rst = 1'b0;
      @(negedge clk);
      check_bit("ready after reset", byte_ready, 1'b1);
   endtask

   task automatic test_basic_load();
      clear_log();
      tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h5C};
      send_stream("basic");
      check_writes("basic", 2, 16'h0000, 16'h0013, 16'h0002, 16'h1237);
      check_bit("basic done", done, 1'b1);
      check_bit("basic cpu_rst", cpu_rst, 1'b0);
      check_bit("basic error", error, 1'b0);
   endtask

   task automatic test_bad_checksum();
      clear_log();
      tx = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00};
      send_stream("badchk");
      check_writes("badchk", 1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
      check_bit("badchk error", error, 1'b1);
      check_bit("badchk cpu_rst", cpu_rst, 1'b1);
      check_bit("badchk done", done, 1'b0);
   endtask

   task automatic test_zero_len();
      clear_log();
      tx = '{8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
      send_stream("zerolen");
      check_writes("zerolen", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check_bit("zerolen done", done, 1'b1);
      check_bit("zerolen error", error, 1'b0);
      check_bit("zerolen cpu_rst", cpu_rst, 1'b0);
   endtask

   task automatic test_oversize();
      clear_log();
      tx = '{8'hA5, 8'h05, 8'h00};
      send_stream("oversize");
      check_writes("oversize", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check_bit("oversize error", error, 1'b1);
      check_bit("oversize cpu_rst", cpu_rst, 1'b1);
      check_bit("oversize done", done, 1'b0);
      clear_log();
      tx = '{8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'h46};
      send_stream("recover");
      check_writes("recover", 1, 16'h0000, 16'h1234, 16'h0000, 16'h0000);
      check_bit("recover done", done, 1'b1);
      check_bit("recover error", error, 1'b0);
   endtask

   task automatic test_back_to_back();
      // SYNC value appears as a data byte and as the checksum; neither restarts the frame.
      clear_log();
      tx = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h01, 8'hA5, 8'hA5};
      send_stream("b2b");
      check_writes("b2b", 2, 16'h0000, 16'h55AA, 16'h0002, 16'hA501);
      check_bit("b2b done", done, 1'b1);
      check_bit("b2b cpu_rst", cpu_rst, 1'b0);
   endtask

   task automatic test_midframe_reset();
      clear_log();
      tx = '{8'hA5, 8'h03, 8'h00};
      send_stream("midframe");
      check_bit("midframe cpu_rst before reset", cpu_rst, 1'b1);
      rst = 1'b1;
      #1;
      check_bit("async rst cpu_rst", cpu_rst, 1'b1);
      check_bit("async rst done", done, 1'b0);
      check_bit("async rst wr_en", wr_en, 1'b0);
      check_bit("async rst ready", byte_ready, 1'b0);
      vec++;
      if (wr_data !== 16'h0000 || wr_addr !== 16'h0000) begin
         errs++;
         $display("FAIL async rst addr/data: got (%h,%h) required (0000,0000)", wr_addr, wr_data);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_log();
      tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h5C};
      send_stream("reload");
      check_writes("reload", 2, 16'h0000, 16'h0013, 16'h0002, 16'h1237);
      check_bit("reload done", done, 1'b1);
      check_bit("reload cpu_rst", cpu_rst, 1'b0);
   endtask

   initial begin
      vec     = 0;
      errs    = 0;
      wr_cnt  = 0;
      rdy_bad = 0;
      test_reset();
      test_basic_load();
      test_bad_checksum();
      test_zero_len();
      test_oversize();
      test_back_to_back();
      test_midframe_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
